// File: rtl/product_bcd_converter_if.sv
// rtl/product_bcd_converter_if.sv - start/result bundle between a requester and the binary-to-BCD converter
interface product_bcd_converter_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;

    modport master (
        output start, bin,
        input  busy, done, bcd, blank
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, blank
    );
endinterface

// File: rtl/product_bcd_converter.sv
// rtl/product_bcd_converter.sv - sequential double-dabble binary-to-BCD converter with leading-zero blanking
module product_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    product_bcd_converter_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = 4 * DIGITS;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]        state_q,   state_d;
    logic [SW-1:0]     scratch_q, scratch_d;
    logic [WIDTH-1:0]  bin_q,     bin_d;
    logic [CW-1:0]     cnt_q,     cnt_d;
    logic [SW-1:0]     bcd_q,     bcd_d;
    logic [DIGITS-1:0] blank_q,   blank_d;

    logic [SW-1:0]     adj;
    logic [SW-1:0]     scratch_shift;
    logic [DIGITS-1:0] blank_calc;
    logic              zero_above;

    // One double-dabble step: add-3 correction, then pull in the next binary MSB.
    always_comb begin
        adj = scratch_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
        scratch_shift = SW'({adj, bin_q[WIDTH-1]});
    end

    // Digit 0 is never blanked so a zero result still shows "0".
    always_comb begin
        blank_calc = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above    = zero_above & (scratch_shift[4*k +: 4] == 4'd0);
            blank_calc[k] = zero_above;
        end
    end

    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        blank_d   = blank_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    bin_d     = bus.bin;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scratch_d = scratch_shift;
                bin_d     = bin_q << 1;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    bcd_d   = scratch_shift;
                    blank_d = blank_calc;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            scratch_q <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            blank_q   <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            blank_q   <= blank_d;
        end
    end

    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.bcd   = bcd_q;
    assign bus.blank = blank_q;
endmodule

// File: tb/tb_product_bcd_converter.sv
// tb/tb_product_bcd_converter.sv - directed-vector and random-sweep bench for product_bcd_converter
module tb_product_bcd_converter;
    logic clk = 1'b0;
    logic reset;

    product_bcd_converter_if #(.WIDTH(16), .DIGITS(5)) bus ();

    product_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
        logic [4:0]  blank;
    } vec_t;

    vec_t vecs [11];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Start a conversion, scramble bin right after acceptance, and check timing and output hold.
    task automatic run_conv(input logic [15:0] v);
        int          lat;
        int          bcnt;
        logic [19:0] held;
        bit          seen;
        bit          hold_ok;
        @(negedge clk);
        bus.bin   = v;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.bin   = ~v;
        held    = bus.bcd;
        bcnt    = bus.busy ? 1 : 0;
        lat     = 0;
        seen    = 1'b0;
        hold_ok = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (bus.busy) bcnt++;
            if (bus.done) seen = 1'b1;
            else if (bus.bcd !== held) hold_ok = 1'b0;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(lat), 32'd16);
        check("busy_cycles", 32'(bcnt), 32'd17);
        check("bcd_hold_during_shift", 32'(hold_ok), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("done_after_pulse", 32'(bus.done), 32'd0);
        check("busy_after_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int          pulses;
        int          first_done;
        logic [15:0] v;
        logic [19:0] exp_bcd;
        int          d;
        bit          digits_ok;

        vecs[0]  = '{16'h0000, 20'h00000, 5'b11110};
        vecs[1]  = '{16'hFE01, 20'h65025, 5'b00000};
        vecs[2]  = '{16'h0064, 20'h00100, 5'b11000};
        vecs[3]  = '{16'hFFFF, 20'h65535, 5'b00000};
        vecs[4]  = '{16'h3039, 20'h12345, 5'b00000};
        vecs[5]  = '{16'h0009, 20'h00009, 5'b11110};
        vecs[6]  = '{16'h000A, 20'h00010, 5'b11100};
        vecs[7]  = '{16'h2710, 20'h10000, 5'b00000};
        vecs[8]  = '{16'h270F, 20'h09999, 5'b10000};
        vecs[9]  = '{16'h03E8, 20'h01000, 5'b10000};
        vecs[10] = '{16'h1234, 20'h04660, 5'b10000};

        // Reset state, with start held high during reset.
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.bin   = 16'h0042;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_bcd", 32'(bus.bcd), 32'h0);
        check("rst_blank", 32'(bus.blank), 32'b11110);

        // First edge with reset low accepts the still-high start.
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("accept_after_reset", 32'(bus.busy), 32'd1);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("post_reset_pulses", 32'(pulses), 32'd1);
        check("post_reset_bcd", 32'(bus.bcd), 32'h00066);

        for (int i = 0; i < 11; i++) begin
            run_conv(vecs[i].bin);
            check($sformatf("vec%0d_bcd", i), 32'(bus.bcd), 32'(vecs[i].bcd));
            check($sformatf("vec%0d_blank", i), 32'(bus.blank), 32'(vecs[i].blank));
        end

        // Start re-asserted mid-conversion at E5 is ignored.
        @(negedge clk);
        bus.bin   = 16'h3039;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.bin   = 16'h0001;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        pulses     = 0;
        first_done = 0;
        for (int e = 6; e < 40; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                pulses++;
                if (first_done == 0) first_done = e;
            end
        end
        check("restart_pulses", 32'(pulses), 32'd1);
        check("restart_done_edge", 32'(first_done), 32'd16);
        check("restart_bcd", 32'(bus.bcd), 32'h12345);

        // Reset at E8 aborts the conversion without a done pulse.
        @(negedge clk);
        bus.bin   = 16'h1234;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_bcd", 32'(bus.bcd), 32'h0);
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        run_conv(16'h1234);
        check("after_abort_bcd", 32'(bus.bcd), 32'h04660);

        // Random sweep against a decimal reference.
        for (int n = 0; n < 1000; n++) begin
            v = 16'($urandom_range(0, 65535));
            exp_bcd = '0;
            d = int'(v);
            for (int k = 0; k < 5; k++) begin
                exp_bcd[4*k +: 4] = 4'(d % 10);
                d = d / 10;
            end
            run_conv(v);
            digits_ok = 1'b1;
            for (int k = 0; k < 5; k++) begin
                if (bus.bcd[4*k +: 4] > 4'd9) digits_ok = 1'b0;
            end
            check($sformatf("rand_bcd_%0h", v), 32'(bus.bcd), 32'(exp_bcd));
            check("rand_digits_le9", 32'(digits_ok), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
